history_checkpoint_queue: RTL and testbench

HISTORY_CHECKPOINT_QUEUE -- requirements
Module: history_checkpoint_queue

---
 rtl/history_checkpoint_queue_if.sv | 32 +++
 rtl/history_checkpoint_queue.sv | 85 ++++++++
 tb/tb_history_checkpoint_queue.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/history_checkpoint_queue_if.sv
// Handshake/bus bundle for the branch-history checkpoint queue.
// master = predictor/resolver side, slave = queue.
interface history_checkpoint_queue_if #(
  parameter int N     = 64,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          pred_valid;
  logic          pred_taken;
  logic [AW-1:0] pred_tag;
  logic          commit_valid;
  logic          mispred_valid;
  logic [AW-1:0] mispred_tag;
  logic          mispred_taken;
  logic [N-1:0]  spec_hist;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  modport master (
    output pred_valid, pred_taken, commit_valid,
    output mispred_valid, mispred_tag, mispred_taken,
    input  pred_tag, spec_hist, count, full, empty
  );

  modport slave (
    input  pred_valid, pred_taken, commit_valid,
    input  mispred_valid, mispred_tag, mispred_taken,
    output pred_tag, spec_hist, count, full, empty
  );
endinterface

// File: rtl/history_checkpoint_queue.sv
// Speculative global-history register with per-branch checkpoints for mispredict restore.
// Outputs registered (1-cycle); predictions stall while full, a mispredict drops a same-cycle prediction.
module history_checkpoint_queue #(
  parameter int N     = 64,
  parameter int DEPTH = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  history_checkpoint_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N-1:0]  r_ckpt [DEPTH];
  logic [N-1:0]  r_spec_hist;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;

  logic          w_pred_acc;
  logic          w_commit_acc;
  logic          w_mis_acc;
  logic [AW-1:0] w_dist;
  logic [AW-1:0] w_head_nxt;
  logic [AW-1:0] w_tail_nxt;
  logic [N-1:0]  w_hist_nxt;
  logic [CW-1:0] w_count_nxt;

  // Age of the mispredicted slot relative to the oldest entry; in range only if occupied.
  assign w_dist       = bus.mispred_tag - r_head;
  assign w_mis_acc    = bus.mispred_valid && ({1'b0, w_dist} < r_count);
  assign w_commit_acc = bus.commit_valid && !r_empty;
  assign w_pred_acc   = bus.pred_valid && !r_full && !bus.mispred_valid;

  always_comb begin
    w_head_nxt  = r_head + AW'(w_commit_acc);
    w_tail_nxt  = r_tail;
    w_hist_nxt  = r_spec_hist;
    w_count_nxt = r_count;
    if (w_mis_acc) begin
      w_tail_nxt  = bus.mispred_tag + AW'(1);
      w_hist_nxt  = {r_ckpt[bus.mispred_tag][N-2:0], bus.mispred_taken};
      w_count_nxt = {1'b0, w_dist} + CW'(1) - CW'(w_commit_acc);
    end else begin
      if (w_pred_acc) begin
        w_tail_nxt = r_tail + AW'(1);
        w_hist_nxt = {r_spec_hist[N-2:0], bus.pred_taken};
      end
      w_count_nxt = r_count + CW'(w_pred_acc) - CW'(w_commit_acc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spec_hist <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
    end else begin
      r_spec_hist <= w_hist_nxt;
      r_head      <= w_head_nxt;
      r_tail      <= w_tail_nxt;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == CW'(DEPTH));
      r_empty     <= (w_count_nxt == '0);
    end
  end

  // Storage is left unreset: only occupied slots can ever be restored from.
  always_ff @(posedge clk) begin
    if (w_pred_acc) begin
      r_ckpt[r_tail] <= r_spec_hist;
    end
  end

  assign bus.pred_tag  = r_tail;
  assign bus.spec_hist = r_spec_hist;
  assign bus.count     = r_count;
  assign bus.full      = r_full;
  assign bus.empty     = r_empty;
endmodule

// File: tb/tb_history_checkpoint_queue.sv
// Randomized and directed bench for history_checkpoint_queue against a queue-based reference model.
module tb_history_checkpoint_queue;
  localparam int N     = 64;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  history_checkpoint_queue_if #(.N(N), .DEPTH(DEPTH)) bus ();

  history_checkpoint_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: saved histories oldest-first, plus the oldest entry's slot number.
  logic [N-1:0] m_q[$];
  logic [N-1:0] m_hist;
  int           m_head;

  function automatic int m_tail();
    return (m_head + m_q.size()) % DEPTH;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic pv, input logic pt, input logic cv,
                              input logic mv, input logic [3:0] mtag, input logic mt);
    int  sz;
    int  d;
    bit  commit_ok;
    logic [N-1:0] saved;
    sz        = m_q.size();
    d         = (int'(mtag) - m_head + DEPTH) % DEPTH;
    commit_ok = cv && (sz > 0);
    if (mv && d < sz) begin
      saved  = m_q[d];
      m_hist = {saved[N-2:0], mt};
      while (m_q.size() > d + 1) void'(m_q.pop_back());
    end else if (pv && sz < DEPTH && !mv) begin
      m_q.push_back(m_hist);
      m_hist = {m_hist[N-2:0], pt};
    end
    if (commit_ok) begin
      void'(m_q.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_hist"},  bus.spec_hist, m_hist);
    check({tag, "_count"}, 64'(bus.count), 64'(m_q.size()));
    check({tag, "_full"},  64'(bus.full),  64'(m_q.size() == DEPTH));
    check({tag, "_empty"}, 64'(bus.empty), 64'(m_q.size() == 0));
  endtask

  // Called at posedge+1; drives one cycle of inputs and checks the result at the next posedge+1.
  task automatic step(input logic pv, input logic pt, input logic cv,
                      input logic mv, input logic [3:0] mtag, input logic mt);
    bus.pred_valid    = pv;
    bus.pred_taken    = pt;
    bus.commit_valid  = cv;
    bus.mispred_valid = mv;
    bus.mispred_tag   = mtag;
    bus.mispred_taken = mt;
    #1;
    check("pred_tag", 64'(bus.pred_tag), 64'(m_tail()));
    @(posedge clk);
    #1;
    model_update(pv, pt, cv, mv, mtag, mt);
    check_outputs("step");
  endtask

  task automatic idle_inputs();
    bus.pred_valid    = 1'b0;
    bus.pred_taken    = 1'b0;
    bus.commit_valid  = 1'b0;
    bus.mispred_valid = 1'b0;
    bus.mispred_tag   = '0;
    bus.mispred_taken = 1'b0;
  endtask

  // Asserts reset between edges, checks it acts without a clock, then holds it across an edge with busy inputs.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    m_q.delete();
    m_hist = '0;
    m_head = 0;
    check_outputs("rst_async");
    check("rst_pred_tag", 64'(bus.pred_tag), 64'd0);
    bus.pred_valid   = 1'b1;
    bus.pred_taken   = 1'b1;
    bus.commit_valid = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("rst_held");
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] snap;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    idle_inputs();
    m_hist = '0;
    m_head = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Three predictions 1,0,1
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    check("s3_hist_low", 64'(bus.spec_hist[2:0]), 64'd5);
    check("s3_count", 64'(bus.count), 64'd3);
    check("s3_empty", 64'(bus.empty), 64'd0);
    check("s3_tag", 64'(bus.pred_tag), 64'd3);

    // Fill, overflow attempt, then commit and commit+pred across the wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 1'($urandom), 0, 0, 0, 0);
    check("fill_full", 64'(bus.full), 64'd1);
    snap = bus.spec_hist;
    step(1, 1, 0, 0, 0, 0);
    check("ovf_hist", bus.spec_hist, snap);
    check("ovf_count", 64'(bus.count), 64'(DEPTH));
    step(0, 0, 1, 0, 0, 0);
    check("cmt_count", 64'(bus.count), 64'(DEPTH - 1));
    step(1, 1, 1, 0, 0, 0);
    check("cp_count", 64'(bus.count), 64'(DEPTH - 1));
    check("cp_tag_wrap", 64'(bus.pred_tag), 64'd1);

    // Five predictions, mispredict on tag 2
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1'($urandom), 0, 0, 0, 0);
    snap = m_q[2];
    step(0, 0, 0, 1, 4'd2, 0);
    check("mis_hist", bus.spec_hist, {snap[N-2:0], 1'b0});
    check("mis_count", 64'(bus.count), 64'd3);
    check("mis_tag", 64'(bus.pred_tag), 64'd3);

    // Prediction loses to a same-cycle mispredict
    step(1, 1, 0, 1, 4'd1, 1);
    check("mp_tag", 64'(bus.pred_tag), 64'd2);
    check("mp_count", 64'(bus.count), 64'd2);

    // Commit on empty, out-of-range mispredict
    do_reset();
    step(0, 0, 1, 0, 0, 0);
    check("cmt_empty_count", 64'(bus.count), 64'd0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    snap = bus.spec_hist;
    step(0, 0, 0, 1, 4'd5, 1);
    check("oor_hist", bus.spec_hist, snap);
    check("oor_count", 64'(bus.count), 64'd2);
    check("oor_tag", 64'(bus.pred_tag), 64'd2);

    // Async reset with four occupied entries
    for (int i = 0; i < 2; i++) step(1, 1, 0, 0, 0, 0);
    check("pre_rst_count", 64'(bus.count), 64'd4);
    do_reset();
    check("post_rst_tag", 64'(bus.pred_tag), 64'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] tag;
      tag = 4'($urandom);
      if (($urandom % 8) == 0 && m_q.size() > 0)
        tag = 4'((m_head + int'($urandom % m_q.size())) % DEPTH);
      step(($urandom % 4) != 0, 1'($urandom), ($urandom % 3) == 0,
           ($urandom % 8) == 0, tag, 1'($urandom));
      if (($urandom % 300) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
